// File: rtl/ifq_pkg.sv
// Shared opcode/funct constants and queue entry type for the instruction fetch queue.
package ifq_pkg;

  localparam int unsigned INS_W = 32;
  localparam int unsigned PC_W  = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] FN_JR    = 6'h08;

  typedef struct packed {
    logic [INS_W-1:0] ins;
    logic [PC_W-1:0]  pc;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_pair_check.sv
// Dual-issue legality of the two head instructions: no control in either slot,
// no memory op in the younger slot, and no RAW from head0 into head1.
module ifq_pair_check
  import ifq_pkg::*;
(
  input  logic [31:0] head0_ins,
  input  logic [31:0] head1_ins,
  input  logic        head1_valid,
  output logic        pair_ok
);

  logic [5:0] op0, op1, fn0, fn1;
  logic [4:0] dest0, rs1, rt1;
  logic       ctrl0, ctrl1, mem1, raw;
  logic       unused_bits;

  assign op0 = head0_ins[31:26];
  assign fn0 = head0_ins[5:0];
  assign op1 = head1_ins[31:26];
  assign fn1 = head1_ins[5:0];
  assign rs1 = head1_ins[25:21];
  assign rt1 = head1_ins[20:16];
  assign unused_bits = ^{head0_ins[10:6], head1_ins[15:6]};

  always_comb begin
    ctrl0 = ((op0 == OP_RTYPE) && (fn0 == FN_JR)) || (op0 == OP_JAL) || (op0 == OP_BEQ);
    ctrl1 = ((op1 == OP_RTYPE) && (fn1 == FN_JR)) || (op1 == OP_JAL) || (op1 == OP_BEQ);
    mem1  = (op1 == OP_LW) || (op1 == OP_SW);

    // Only R-type, addi and jal are treated as writing a register.
    dest0 = 5'd0;
    if (op0 == OP_RTYPE) begin
      dest0 = head0_ins[15:11];
    end else if (op0 == OP_ADDI) begin
      dest0 = head0_ins[20:16];
    end else if (op0 == OP_JAL) begin
      dest0 = 5'd31;
    end

    raw     = (dest0 != 5'd0) && ((dest0 == rs1) || (dest0 == rt1));
    pair_ok = head1_valid && !ctrl0 && !ctrl1 && !mem1 && !raw;
  end

endmodule

// File: rtl/ifq_fetch_queue.sv
// Show-ahead instruction fetch queue: one pair in, up to two out per cycle.
// Optional IFQ_PAIR_CHECK_EN gates pair_ok with a hazard/legality check.
module ifq_fetch_queue
  import ifq_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          in_valid,
  input  logic [31:0]   in_ins1,
  input  logic [31:0]   in_ins2,
  input  logic [31:0]   in_pc,
  output logic          in_ready,
  input  logic [1:0]    deq_cnt,
  output logic          head0_valid,
  output logic [31:0]   head0_ins,
  output logic [31:0]   head0_pc,
  output logic          head1_valid,
  output logic [31:0]   head1_ins,
  output logic [31:0]   head1_pc,
  output logic [AW:0]   count,
  output logic          pair_ok
);

  localparam int unsigned CW = AW + 1;

  ifq_entry_t mem_q [DEPTH];
  ifq_entry_t mem_d [DEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [CW-1:0] count_q, count_d;

  logic          push;
  logic [1:0]    req;
  logic [CW-1:0] pop_amt;
  ifq_entry_t    ent0, ent1;

  // Space check uses registered occupancy only; same-cycle pops do not free room.
  assign in_ready = (count_q <= CW'(DEPTH - 2));
  assign count    = count_q;

  always_comb begin
    push    = in_valid && in_ready && !flush;
    req     = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
    pop_amt = (count_q < CW'(req)) ? count_q : CW'(req);
    if (flush) begin
      pop_amt = '0;
    end

    mem_d   = mem_q;
    rp_d    = rp_q + AW'(pop_amt);
    wp_d    = wp_q;
    count_d = count_q - pop_amt;

    if (push) begin
      mem_d[wp_q]             = '{ins: in_ins1, pc: in_pc};
      mem_d[AW'(wp_q + 1'b1)] = '{ins: in_ins2, pc: in_pc + 32'd1};
      wp_d    = wp_q + AW'(2);
      count_d = count_q + CW'(2) - pop_amt;
    end

    if (flush) begin
      rp_d    = '0;
      wp_d    = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q    <= '0;
      wp_q    <= '0;
      count_q <= '0;
    end else begin
      rp_q    <= rp_d;
      wp_q    <= wp_d;
      count_q <= count_d;
    end
  end

  // Entry storage is not reset; validity comes from count_q.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    ent0        = mem_q[rp_q];
    ent1        = mem_q[AW'(rp_q + 1'b1)];
    head0_valid = (count_q >= CW'(1));
    head1_valid = (count_q >= CW'(2));
    head0_ins   = head0_valid ? ent0.ins : 32'd0;
    head0_pc    = head0_valid ? ent0.pc  : 32'd0;
    head1_ins   = head1_valid ? ent1.ins : 32'd0;
    head1_pc    = head1_valid ? ent1.pc  : 32'd0;
  end

`ifdef IFQ_PAIR_CHECK_EN
  ifq_pair_check u_pair_check (
    .head0_ins   (head0_ins),
    .head1_ins   (head1_ins),
    .head1_valid (head1_valid),
    .pair_ok     (pair_ok)
  );
`else
  assign pair_ok = head1_valid;
`endif

endmodule

// File: tb/tb_ifq_fetch_queue.sv
// Directed, table-driven bench for ifq_fetch_queue (DEPTH=8).
module tb_ifq_fetch_queue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic [31:0] in_ins1, in_ins2, in_pc;
  logic [1:0]  deq_cnt;
  logic        head0_valid, head1_valid, pair_ok;
  logic [31:0] head0_ins, head0_pc, head1_ins, head1_pc;
  logic [3:0]  count;

  int checks = 0;
  int errors = 0;

  ifq_fetch_queue #(.DEPTH(8), .AW(3)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_ins1(in_ins1), .in_ins2(in_ins2), .in_pc(in_pc), .in_ready(in_ready),
    .deq_cnt(deq_cnt), .head0_valid(head0_valid), .head0_ins(head0_ins),
    .head0_pc(head0_pc), .head1_valid(head1_valid), .head1_ins(head1_ins),
    .head1_pc(head1_pc), .count(count), .pair_ok(pair_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fl;
    logic        v;
    logic [31:0] i1, i2, pc;
    logic [1:0]  deq;
    logic [3:0]  cnt;
    logic        rdy, h0v;
    logic [31:0] h0ins, h0pc;
    logic        h1v;
    logic [31:0] h1ins, h1pc;
  } vec_t;

  vec_t vecs[17];

  function automatic vec_t mk(logic fl, logic v, logic [31:0] i1, logic [31:0] i2,
                              logic [31:0] pc, logic [1:0] deq, logic [3:0] cnt,
                              logic rdy, logic h0v, logic [31:0] h0ins, logic [31:0] h0pc,
                              logic h1v, logic [31:0] h1ins, logic [31:0] h1pc);
    vec_t r;
    r.fl = fl; r.v = v; r.i1 = i1; r.i2 = i2; r.pc = pc; r.deq = deq;
    r.cnt = cnt; r.rdy = rdy; r.h0v = h0v; r.h0ins = h0ins; r.h0pc = h0pc;
    r.h1v = h1v; r.h1ins = h1ins; r.h1pc = h1pc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic r, input logic fl, input logic v, input logic [31:0] i1,
                      input logic [31:0] i2, input logic [31:0] pc, input logic [1:0] deq);
    rst = r; flush = fl; in_valid = v; in_ins1 = i1; in_ins2 = i2; in_pc = pc; deq_cnt = deq;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".count"}, 32'(count), 32'd0);
    chk({tag, ".h0v"}, 32'(head0_valid), 32'd0);
    chk({tag, ".h0ins"}, head0_ins, 32'd0);
    chk({tag, ".h1pc"}, head1_pc, 32'd0);
    chk({tag, ".pair_ok"}, 32'(pair_ok), 32'd0);
    chk({tag, ".rdy"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    vecs[0]  = mk(0,1,32'h20080001,32'h20090002,32'h10,0, 2,1,1,32'h20080001,32'h10,1,32'h20090002,32'h11);
    vecs[1]  = mk(0,1,32'hA0000020,32'hB0000021,32'h20,0, 4,1,1,32'h20080001,32'h10,1,32'h20090002,32'h11);
    vecs[2]  = mk(0,1,32'hA0000030,32'hB0000031,32'h30,0, 6,1,1,32'h20080001,32'h10,1,32'h20090002,32'h11);
    vecs[3]  = mk(0,1,32'hA0000040,32'hB0000041,32'h40,0, 8,0,1,32'h20080001,32'h10,1,32'h20090002,32'h11);
    vecs[4]  = mk(0,1,32'hA0000050,32'hB0000051,32'h50,0, 8,0,1,32'h20080001,32'h10,1,32'h20090002,32'h11);
    vecs[5]  = mk(0,0,32'h0,32'h0,32'h0,3,                 6,1,1,32'hA0000020,32'h20,1,32'hB0000021,32'h21);
    vecs[6]  = mk(0,0,32'h0,32'h0,32'h0,1,                 5,1,1,32'hB0000021,32'h21,1,32'hA0000030,32'h30);
    vecs[7]  = mk(0,0,32'h0,32'h0,32'h0,2,                 3,1,1,32'hB0000031,32'h31,1,32'hA0000040,32'h40);
    vecs[8]  = mk(0,1,32'hA0000060,32'hB0000061,32'h60,2, 3,1,1,32'hB0000041,32'h41,1,32'hA0000060,32'h60);
    vecs[9]  = mk(0,0,32'h0,32'h0,32'h0,2,                 1,1,1,32'hB0000061,32'h61,0,32'h0,32'h0);
    vecs[10] = mk(0,0,32'h0,32'h0,32'h0,2,                 0,1,0,32'h0,32'h0,0,32'h0,32'h0);
    vecs[11] = mk(0,0,32'h0,32'h0,32'h0,1,                 0,1,0,32'h0,32'h0,0,32'h0,32'h0);
    vecs[12] = mk(0,1,32'hA0000070,32'hB0000071,32'h70,0, 2,1,1,32'hA0000070,32'h70,1,32'hB0000071,32'h71);
    vecs[13] = mk(0,1,32'hA0000080,32'hB0000081,32'h80,0, 4,1,1,32'hA0000070,32'h70,1,32'hB0000071,32'h71);
    vecs[14] = mk(0,1,32'hA0000090,32'hB0000091,32'h90,0, 6,1,1,32'hA0000070,32'h70,1,32'hB0000071,32'h71);
    vecs[15] = mk(1,1,32'hA00000A0,32'hB00000A1,32'hA0,1, 0,1,0,32'h0,32'h0,0,32'h0,32'h0);
    vecs[16] = mk(0,1,32'hA00000B0,32'hB00000B1,32'hB0,0, 2,1,1,32'hA00000B0,32'hB0,1,32'hB00000B1,32'hB1);

    // Reset state
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk_empty("reset");

    for (int i = 0; i < 17; i++) begin
      step(0, vecs[i].fl, vecs[i].v, vecs[i].i1, vecs[i].i2, vecs[i].pc, vecs[i].deq);
      chk($sformatf("v%0d.count", i), 32'(count), 32'(vecs[i].cnt));
      chk($sformatf("v%0d.rdy", i), 32'(in_ready), 32'(vecs[i].rdy));
      chk($sformatf("v%0d.h0v", i), 32'(head0_valid), 32'(vecs[i].h0v));
      chk($sformatf("v%0d.h0ins", i), head0_ins, vecs[i].h0ins);
      chk($sformatf("v%0d.h0pc", i), head0_pc, vecs[i].h0pc);
      chk($sformatf("v%0d.h1v", i), 32'(head1_valid), 32'(vecs[i].h1v));
      chk($sformatf("v%0d.h1ins", i), head1_ins, vecs[i].h1ins);
      chk($sformatf("v%0d.h1pc", i), head1_pc, vecs[i].h1pc);
      chk($sformatf("v%0d.pair_ok", i), 32'(pair_ok), 32'(vecs[i].h1v));
    end

    // Continuous push + pop-2 for 20 cycles across many pointer wraps
    for (int k = 0; k < 20; k++) begin
      logic [31:0] p;
      p = 32'hB2 + 32'(2 * k);
      step(0, 0, 1, 32'hA0000000 | p, 32'hB0000000 | (p + 32'd1), p, 2);
      chk($sformatf("wrap%0d.count", k), 32'(count), 32'd2);
      chk($sformatf("wrap%0d.h0pc", k), head0_pc, p);
      chk($sformatf("wrap%0d.h0ins", k), head0_ins, 32'hA0000000 | p);
      chk($sformatf("wrap%0d.h1pc", k), head1_pc, p + 32'd1);
    end

    // Reset wins over a concurrent push and pop
    step(1, 0, 1, 32'h1, 32'h2, 32'h300, 1);
    chk_empty("rst_prio");
    step(0, 0, 0, 0, 0, 0, 0);
    chk_empty("post_rst");

`ifdef IFQ_PAIR_CHECK_EN
    // add $3,$1,$2 ; add $5,$3,$4 -> RAW on $3
    step(0, 0, 1, 32'h00221820, 32'h00642820, 32'h400, 0);
    chk("pc.raw", 32'(pair_ok), 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);
    // add $3,$1,$2 ; add $5,$6,$4 -> independent
    step(0, 0, 1, 32'h00221820, 32'h00C42820, 32'h410, 0);
    chk("pc.indep", 32'(pair_ok), 32'd1);
    step(0, 1, 0, 0, 0, 0, 0);
    // add $3,$1,$2 ; lw $7,0($8) -> memory op in younger slot
    step(0, 0, 1, 32'h00221820, 32'h8D070000, 32'h420, 0);
    chk("pc.lw", 32'(pair_ok), 32'd0);
    step(0, 1, 0, 0, 0, 0, 0);
    // beq in older slot blocks pairing
    step(0, 0, 1, 32'h10220004, 32'h00C42820, 32'h430, 0);
    chk("pc.beq", 32'(pair_ok), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
